mux_ctrl_sequencer: RTL and testbench

Symbol-sequencing controller that drives the 4-bit select of the lane symbol multiplexer. It arbitrates between SKP ordered sets, FTS ordered sets, framed TLPs and framed DLLPs, and fills idle time with IDL. It emits one select code per clock; the multiplexer registers the chosen symbol on the following edge. Upstream packet sources see a request/acknowledge handshake plus a per-byte read strobe.

---
 rtl/mux_ctrl_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mux_ctrl_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mux_ctrl_sequencer.sv
// rtl/mux_ctrl_sequencer.sv - lane symbol select sequencer: SKP/FTS ordered sets, TLP/DLLP framing, IDL fill
module mux_ctrl_sequencer #(
    parameter int SKP_INTERVAL = 1180,
    parameter int N_FTS        = 3,
    parameter int DLLP_LEN     = 6
) (
    input  logic       seqCLK,
    input  logic       seqRSTn,
    input  logic       tlpReq,
    input  logic [7:0] tlpLen,
    input  logic       tlpAbort,
    input  logic       dllpReq,
    input  logic       ftsReq,
    output logic [3:0] seqCTRL,
    output logic       tlpRd,
    output logic       tlpAck,
    output logic       dllpAck,
    output logic       ftsAck,
    output logic       seqBusy
);

    typedef enum logic [2:0] {
        IDLE,
        OS_COM,
        OS_SKP,
        OS_FTS,
        PKT_START,
        BODY,
        PKT_END
    } state_t;

    localparam logic [3:0] C_BODY = 4'd0;
    localparam logic [3:0] C_COM  = 4'd1;
    localparam logic [3:0] C_SKP  = 4'd3;
    localparam logic [3:0] C_STP  = 4'd4;
    localparam logic [3:0] C_SDP  = 4'd5;
    localparam logic [3:0] C_END  = 4'd6;
    localparam logic [3:0] C_EDB  = 4'd7;
    localparam logic [3:0] C_FTS  = 4'd8;
    localparam logic [3:0] C_IDL  = 4'd9;
    localparam logic [3:0] C_INV  = 4'hF;

    localparam logic [10:0] SKP_LAST = 11'(SKP_INTERVAL - 1);

    // state names the symbol currently on seqCTRL; all outputs are derived from next_state
    state_t      state, next_state;
    logic [7:0]  cnt, cnt_n;
    logic        is_tlp, is_tlp_n;
    logic        os_fts, os_fts_n;
    logic        aborted, aborted_n;
    logic [10:0] skp_cnt;
    logic        skp_pend;
    logic        pend_clr;
    logic        arb;
    logic [3:0]  ctrl_n;
    logic        tack_n, dack_n, fack_n;
    logic        skp_wrap;

    assign skp_wrap = (skp_cnt == SKP_LAST);

    always_comb begin
        next_state = state;
        cnt_n      = cnt;
        is_tlp_n   = is_tlp;
        os_fts_n   = os_fts;
        aborted_n  = aborted;
        tack_n     = 1'b0;
        dack_n     = 1'b0;
        fack_n     = 1'b0;
        pend_clr   = 1'b0;
        arb        = 1'b0;
        ctrl_n     = C_IDL;

        case (state)
            IDLE, PKT_END: arb = 1'b1;
            OS_COM: begin
                next_state = os_fts ? OS_FTS : OS_SKP;
                cnt_n      = os_fts ? 8'(N_FTS) : 8'd3;
            end
            OS_SKP, OS_FTS: begin
                if (cnt == 8'd1) next_state = IDLE;
                else             cnt_n = cnt - 8'd1;
            end
            PKT_START: next_state = BODY;
            BODY: begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1 || (is_tlp && tlpAbort)) begin
                    next_state = PKT_END;
                    aborted_n  = is_tlp && tlpAbort;
                end
            end
            default: next_state = IDLE;
        endcase

        // packet-boundary arbitration: skpPend > ftsReq > tlpReq > dllpReq
        if (arb) begin
            next_state = IDLE;
            aborted_n  = 1'b0;
            if (skp_pend) begin
                next_state = OS_COM;
                os_fts_n   = 1'b0;
                pend_clr   = 1'b1;
            end else if (ftsReq) begin
                next_state = OS_COM;
                os_fts_n   = 1'b1;
                fack_n     = 1'b1;
            end else if (tlpReq) begin
                next_state = PKT_START;
                is_tlp_n   = 1'b1;
                cnt_n      = (tlpLen == 8'd0) ? 8'd1 : tlpLen;
                tack_n     = 1'b1;
            end else if (dllpReq) begin
                next_state = PKT_START;
                is_tlp_n   = 1'b0;
                cnt_n      = 8'(DLLP_LEN);
                dack_n     = 1'b1;
            end
        end

        case (next_state)
            IDLE:      ctrl_n = C_IDL;
            OS_COM:    ctrl_n = C_COM;
            OS_SKP:    ctrl_n = C_SKP;
            OS_FTS:    ctrl_n = C_FTS;
            PKT_START: ctrl_n = is_tlp_n ? C_STP : C_SDP;
            BODY:      ctrl_n = C_BODY;
            PKT_END:   ctrl_n = aborted_n ? C_EDB : C_END;
            default:   ctrl_n = C_INV;
        endcase
    end

    always_ff @(posedge seqCLK) begin
        if (!seqRSTn) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            is_tlp   <= 1'b0;
            os_fts   <= 1'b0;
            aborted  <= 1'b0;
            skp_cnt  <= 11'd0;
            skp_pend <= 1'b0;
            seqCTRL  <= C_INV;
            tlpRd    <= 1'b0;
            tlpAck   <= 1'b0;
            dllpAck  <= 1'b0;
            ftsAck   <= 1'b0;
            seqBusy  <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_n;
            is_tlp  <= is_tlp_n;
            os_fts  <= os_fts_n;
            aborted <= aborted_n;
            skp_cnt <= skp_wrap ? 11'd0 : skp_cnt + 11'd1;
            // a wrap coinciding with service keeps the new pend rather than losing it
            if (skp_wrap)      skp_pend <= 1'b1;
            else if (pend_clr) skp_pend <= 1'b0;
            seqCTRL <= ctrl_n;
            tlpRd   <= (next_state == BODY);
            tlpAck  <= tack_n;
            dllpAck <= dack_n;
            ftsAck  <= fack_n;
            seqBusy <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_mux_ctrl_sequencer.sv
// tb/tb_mux_ctrl_sequencer.sv - directed self-checking bench for mux_ctrl_sequencer
module tb_mux_ctrl_sequencer;

    logic       clk;
    logic       resetn;
    logic       tlp_req, dllp_req, fts_req, tlp_abort;
    logic [7:0] tlp_len;

    logic [3:0] ctrl1, ctrl2;
    logic       rd1, tack1, dack1, fack1, busy1;
    logic       rd2, tack2, dack2, fack2, busy2;

    int total = 0;
    int bad   = 0;

    mux_ctrl_sequencer #(.SKP_INTERVAL(1180), .N_FTS(3), .DLLP_LEN(6)) u_dut (
        .seqCLK(clk), .seqRSTn(resetn), .tlpReq(tlp_req), .tlpLen(tlp_len),
        .tlpAbort(tlp_abort), .dllpReq(dllp_req), .ftsReq(fts_req),
        .seqCTRL(ctrl1), .tlpRd(rd1), .tlpAck(tack1), .dllpAck(dack1),
        .ftsAck(fack1), .seqBusy(busy1)
    );

    // short-interval instance for the SKP scenario
    mux_ctrl_sequencer #(.SKP_INTERVAL(16), .N_FTS(3), .DLLP_LEN(6)) u_dut_skp (
        .seqCLK(clk), .seqRSTn(resetn), .tlpReq(tlp_req), .tlpLen(tlp_len),
        .tlpAbort(tlp_abort), .dllpReq(dllp_req), .ftsReq(fts_req),
        .seqCTRL(ctrl2), .tlpRd(rd2), .tlpAck(tack2), .dllpAck(dack2),
        .ftsAck(fack2), .seqBusy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic e1(input string tag, input logic [3:0] c, input logic rd, input logic ta,
                      input logic da, input logic fa, input logic b);
        chk({tag, "_ctrl"}, 32'(ctrl1), 32'(c));
        chk({tag, "_rd"},   32'(rd1),   32'(rd));
        chk({tag, "_tack"}, 32'(tack1), 32'(ta));
        chk({tag, "_dack"}, 32'(dack1), 32'(da));
        chk({tag, "_fack"}, 32'(fack1), 32'(fa));
        chk({tag, "_busy"}, 32'(busy1), 32'(b));
    endtask

    task automatic e2(input string tag, input logic [3:0] c, input logic rd, input logic ta,
                      input logic da, input logic b);
        chk({tag, "_ctrl"}, 32'(ctrl2), 32'(c));
        chk({tag, "_rd"},   32'(rd2),   32'(rd));
        chk({tag, "_tack"}, 32'(tack2), 32'(ta));
        chk({tag, "_dack"}, 32'(dack2), 32'(da));
        chk({tag, "_busy"}, 32'(busy2), 32'(b));
    endtask

    task automatic do_reset(input string tag);
        resetn    = 1'b0;
        tlp_req   = 1'b0;
        dllp_req  = 1'b0;
        fts_req   = 1'b0;
        tlp_abort = 1'b0;
        tlp_len   = 8'd0;
        step();
        step();
        e1(tag, 4'hF, 0, 0, 0, 0, 0);
        resetn = 1'b1;
    endtask

    initial begin
        // idle fill after reset
        do_reset("t1_rst");
        for (int i = 0; i < 20; i++) begin
            step();
            e1($sformatf("t1_idle%0d", i), 4'd9, 0, 0, 0, 0, 0);
        end

        // single TLP, length 3
        do_reset("t2_rst");
        tlp_len = 8'd3;
        tlp_req = 1'b1;
        step(); e1("t2_stp", 4'd4, 0, 1, 0, 0, 1);
        tlp_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); e1($sformatf("t2_b%0d", i), 4'd0, 1, 0, 0, 0, 1);
        end
        step(); e1("t2_end", 4'd6, 0, 0, 0, 0, 1);
        step(); e1("t2_idl", 4'd9, 0, 0, 0, 0, 0);

        // TLP then DLLP back-to-back; abort held during DLLP body must be ignored
        do_reset("t3_rst");
        tlp_len  = 8'd1;
        tlp_req  = 1'b1;
        dllp_req = 1'b1;
        step(); e1("t3_stp", 4'd4, 0, 1, 0, 0, 1);
        tlp_req = 1'b0;
        step(); e1("t3_tb", 4'd0, 1, 0, 0, 0, 1);
        step(); e1("t3_tend", 4'd6, 0, 0, 0, 0, 1);
        step(); e1("t3_sdp", 4'd5, 0, 0, 1, 0, 1);
        dllp_req  = 1'b0;
        tlp_abort = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(); e1($sformatf("t3_db%0d", i), 4'd0, 1, 0, 0, 0, 1);
        end
        step(); e1("t3_dend", 4'd6, 0, 0, 0, 0, 1);
        tlp_abort = 1'b0;
        step(); e1("t3_idl", 4'd9, 0, 0, 0, 0, 0);

        // abort on the 2nd body byte of a 5-byte TLP
        do_reset("t4_rst");
        tlp_len = 8'd5;
        tlp_req = 1'b1;
        step(); e1("t4_stp", 4'd4, 0, 1, 0, 0, 1);
        tlp_req = 1'b0;
        step(); e1("t4_b0", 4'd0, 1, 0, 0, 0, 1);
        step(); e1("t4_b1", 4'd0, 1, 0, 0, 0, 1);
        tlp_abort = 1'b1;
        step(); e1("t4_edb", 4'd7, 0, 0, 0, 0, 1);
        tlp_abort = 1'b0;
        step(); e1("t4_idl", 4'd9, 0, 0, 0, 0, 0);

        // zero length is sent as one body byte
        do_reset("t5_rst");
        tlp_len = 8'd0;
        tlp_req = 1'b1;
        step(); e1("t5_stp", 4'd4, 0, 1, 0, 0, 1);
        tlp_req = 1'b0;
        step(); e1("t5_b0", 4'd0, 1, 0, 0, 0, 1);
        step(); e1("t5_end", 4'd6, 0, 0, 0, 0, 1);
        step(); e1("t5_idl", 4'd9, 0, 0, 0, 0, 0);

        // FTS beats a pending TLP, then reset lands mid-body
        do_reset("t6_rst");
        tlp_len = 8'd4;
        fts_req = 1'b1;
        tlp_req = 1'b1;
        step(); e1("t6_com", 4'd1, 0, 0, 0, 1, 1);
        fts_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); e1($sformatf("t6_fts%0d", i), 4'd8, 0, 0, 0, 0, 1);
        end
        step(); e1("t6_gap", 4'd9, 0, 0, 0, 0, 0);
        step(); e1("t6_stp", 4'd4, 0, 1, 0, 0, 1);
        tlp_req = 1'b0;
        step(); e1("t6_b0", 4'd0, 1, 0, 0, 0, 1);
        step(); e1("t6_b1", 4'd0, 1, 0, 0, 0, 1);
        resetn = 1'b0;
        step(); e1("t6_inrst", 4'hF, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); e1($sformatf("t6_post%0d", i), 4'd9, 0, 0, 0, 0, 0);
        end

        // SKP interval 16 elapses during a 20-byte TLP; DLLP waits behind the SKP set
        do_reset("t7_rst");
        tlp_len  = 8'd20;
        tlp_req  = 1'b1;
        dllp_req = 1'b1;
        step(); e2("t7_stp", 4'd4, 0, 1, 0, 1);
        tlp_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(); e2($sformatf("t7_b%0d", i), 4'd0, 1, 0, 0, 1);
        end
        step(); e2("t7_end", 4'd6, 0, 0, 0, 1);
        step(); e2("t7_com", 4'd1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(); e2($sformatf("t7_skp%0d", i), 4'd3, 0, 0, 0, 1);
        end
        step(); e2("t7_gap", 4'd9, 0, 0, 0, 0);
        step(); e2("t7_sdp", 4'd5, 0, 0, 1, 1);
        dllp_req = 1'b0;
        step(); e2("t7_db0", 4'd0, 1, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
